// File: rtl/irq_priority_encoder_4x2.sv
// Sequential 4-to-2 interrupt priority encoder.
// Sticky pending capture, masked selection, held valid/ack presentation.
module irq_priority_encoder_4x2 #(
  parameter int N_REQ  = 4,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  mask,
  input  logic              ack,
  input  logic              clr_lost,
  output logic [CODE_W-1:0] enc_code,
  output logic              enc_valid,
  output logic [N_REQ-1:0]  pending,
  output logic              lost
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t             state;
  logic [N_REQ-1:0]   req_q;
  logic [N_REQ-1:0]   rise;
  logic [N_REQ-1:0]   sel;
  logic [N_REQ-1:0]   clr_vec;
  logic [N_REQ-1:0]   pending_n;
  logic [CODE_W-1:0]  sel_code;
  logic               take;
  logic               lost_set;

  assign rise = req & ~req_q;
  assign sel  = pending & mask;
  assign take = (state == PRESENT) && ack;

  always_comb begin
    sel_code = '0;
    if (sel[3])      sel_code = 2'd3;
    else if (sel[2]) sel_code = 2'd2;
    else if (sel[1]) sel_code = 2'd1;
    else if (sel[0]) sel_code = 2'd0;
  end

  always_comb begin
    clr_vec = '0;
    if (take) clr_vec[enc_code] = 1'b1;
  end

  // A new edge wins over a coincident ack-clear and is not counted as lost
  assign pending_n = (pending & ~clr_vec) | rise;
  assign lost_set  = |(rise & pending & ~clr_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      pending <= '0;
      lost    <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= pending_n;
      if (lost_set)      lost <= 1'b1;
      else if (clr_lost) lost <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      enc_code  <= '0;
      enc_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|sel) begin
            enc_code  <= sel_code;
            enc_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            enc_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          enc_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_encoder_4x2.sv
// Directed bench for irq_priority_encoder_4x2.
// Inputs change 1ns after posedge; outputs are checked at that point.
module tb_irq_priority_encoder_4x2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic       clr_lost;
  logic [1:0] enc_code;
  logic       enc_valid;
  logic [3:0] pending;
  logic       lost;

  int n_cmp = 0;
  int n_err = 0;

  irq_priority_encoder_4x2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .ack       (ack),
    .clr_lost  (clr_lost),
    .enc_code  (enc_code),
    .enc_valid (enc_valid),
    .pending   (pending),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; mask = 4'hF;
    ack = 1'b0; clr_lost = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({enc_code, enc_valid, pending, lost} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got code=%0d v=%0b p=%b l=%0b want all 0",
               enc_code, enc_valid, pending, lost);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    n_cmp++;
    if (pending !== 4'b0100 || enc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pend: got p=%b v=%0b want p=0100 v=0",
               pending, enc_valid);
    end
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd2) begin
      n_err++;
      $display("FAIL single_valid: got v=%0b c=%0d want v=1 c=2",
               enc_valid, enc_code);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (enc_valid !== 1'b1 || enc_code !== 2'd2) begin
        n_err++;
        $display("FAIL single_hold%0d: got v=%0b c=%0d want v=1 c=2",
                 i, enc_valid, enc_code);
      end
    end
    ack = 1'b1; req = '0;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (enc_valid !== 1'b0 || pending !== 4'b0000) begin
      n_err++;
      $display("FAIL single_ack: got v=%0b p=%b want v=0 p=0000",
               enc_valid, pending);
    end
  endtask

  task automatic test_priority();
    logic [1:0] exp_code [3];
    logic [3:0] exp_pend [3];
    exp_code = '{2'd3, 2'd1, 2'd0};
    exp_pend = '{4'b0011, 4'b0001, 4'b0000};
    req = 4'b1011;
    tick();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (enc_valid !== 1'b1 || enc_code !== exp_code[i]) begin
        n_err++;
        $display("FAIL prio_code%0d: got v=%0b c=%0d want v=1 c=%0d",
                 i, enc_valid, enc_code, exp_code[i]);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_cmp++;
      if (enc_valid !== 1'b0 || pending !== exp_pend[i]) begin
        n_err++;
        $display("FAIL prio_gap%0d: got v=%0b p=%b want v=0 p=%b",
                 i, enc_valid, pending, exp_pend[i]);
      end
    end
  endtask

  task automatic test_mask();
    mask = 4'b0111; req = 4'b1001;
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd0) begin
      n_err++;
      $display("FAIL mask_low: got v=%0b c=%0d want v=1 c=0",
               enc_valid, enc_code);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_cmp++;
    if (enc_valid !== 1'b0 || pending !== 4'b1000) begin
      n_err++;
      $display("FAIL mask_held: got v=%0b p=%b want v=0 p=1000",
               enc_valid, pending);
    end
    mask = 4'hF;
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd3) begin
      n_err++;
      $display("FAIL mask_unmask: got v=%0b c=%0d want v=1 c=3",
               enc_valid, enc_code);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_no_preempt();
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd1 || pending !== 4'b1010) begin
      n_err++;
      $display("FAIL nopre_hold: got v=%0b c=%0d p=%b want v=1 c=1 p=1010",
               enc_valid, enc_code, pending);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (enc_valid !== 1'b0 || pending !== 4'b1000) begin
      n_err++;
      $display("FAIL nopre_gap: got v=%0b p=%b want v=0 p=1000",
               enc_valid, pending);
    end
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd3) begin
      n_err++;
      $display("FAIL nopre_next: got v=%0b c=%0d want v=1 c=3",
               enc_valid, enc_code);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_lost();
    req = 4'b0100;
    tick();
    tick();
    req = '0;
    tick();
    req = 4'b0100;
    tick();
    n_cmp++;
    if (lost !== 1'b1 || pending !== 4'b0100) begin
      n_err++;
      $display("FAIL lost_set: got l=%0b p=%b want l=1 p=0100",
               lost, pending);
    end
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    n_cmp++;
    if (lost !== 1'b0) begin
      n_err++;
      $display("FAIL lost_clr: got l=%0b want l=0", lost);
    end
    req = '0;
    tick();
    req = 4'b0100; ack = 1'b1;
    tick();
    ack = 1'b0; req = '0;
    n_cmp++;
    if (pending !== 4'b0100 || lost !== 1'b0 || enc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lost_coinc: got p=%b l=%0b v=%0b want p=0100 l=0 v=0",
               pending, lost, enc_valid);
    end
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd2) begin
      n_err++;
      $display("FAIL lost_repres: got v=%0b c=%0d want v=1 c=2",
               enc_valid, enc_code);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    req = 4'b1110;
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd3 ||
        pending !== 4'b1110 || lost !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre: got v=%0b c=%0d p=%b l=%0b want v=1 c=3 p=1110 l=1",
               enc_valid, enc_code, pending, lost);
    end
    req = 4'b0001;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({enc_code, enc_valid, pending, lost} !== 8'h00) begin
      n_err++;
      $display("FAIL rmid_async: got c=%0d v=%0b p=%b l=%0b want all 0",
               enc_code, enc_valid, pending, lost);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (enc_valid !== 1'b0 || pending !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_rel1: got v=%0b p=%b want v=0 p=0001",
               enc_valid, pending);
    end
    tick();
    n_cmp++;
    if (enc_valid !== 1'b1 || enc_code !== 2'd0) begin
      n_err++;
      $display("FAIL rmid_rel2: got v=%0b c=%0d want v=1 c=0",
               enc_valid, enc_code);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_no_preempt();
    test_lost();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
